// File: rtl/alu_array_4b.sv
// alu_array_4b: per-stage action engine.
// Sixty-four 32-bit ALUs, one per 4-byte container, rebuild the PHV as
// {result[63..0], remainder}. The result leaves through a registered output
// stage backed by a one-entry skid buffer, so the stage holds at most two PHVs.
//
// Handshake: the upstream side offers a PHV with alu_in_valid and it is taken
// on a rising edge where ready_out is high. ready_out is registered and equals
// "skid empty", so it falls the cycle after the skid fills. A PHV offered while
// ready_out is low is dropped and counted. The downstream side takes phv_out
// on a rising edge where phv_out_valid and ready_in are both high. While
// phv_out_valid is high and ready_in is low, phv_out does not change.
module alu_array_4b #(
    parameter int STAGE_ID   = 0,
    parameter int PHV_LEN    = 4*8*64+256,
    parameter int ACT_LEN    = 64,
    parameter int C_NUM_PHVS = 65,
    parameter int width_4B   = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_in_valid,
    input  logic [width_4B*64-1:0]        alu_in_4B_1,
    input  logic [width_4B*64-1:0]        alu_in_4B_2,
    input  logic [width_4B*64-1:0]        alu_in_4B_3,
    input  logic [255:0]                  phv_remain_data,
    input  logic [ACT_LEN*C_NUM_PHVS-1:0] action_in,
    input  logic                          action_in_valid,
    output logic                          ready_out,
    output logic [PHV_LEN-1:0]            phv_out,
    output logic                          phv_out_valid,
    input  logic                          ready_in,
    output logic [15:0]                   drop_cnt,
    output logic [15:0]                   act_miss_cnt
);

    localparam int NUM_C = 64;

    // Only the opcode byte of each sub-action is used. Sub-action 0 is
    // reserved, and STAGE_ID is informational.
    logic unused_bits;
    assign unused_bits = ^{action_in, STAGE_ID[0]};

    logic [width_4B*NUM_C-1:0] res_vec;
    logic [PHV_LEN-1:0]        phv_new;

    logic [PHV_LEN-1:0] phv_q, phv_d;
    logic               out_valid_q, out_valid_d;
    logic [PHV_LEN-1:0] skid_q, skid_d;
    logic               skid_valid_q, skid_valid_d;
    logic               ready_q, ready_d;
    logic [15:0]        drop_cnt_q, drop_cnt_d;
    logic [15:0]        miss_cnt_q, miss_cnt_d;

    logic accept;
    logic drain;
    logic drop;

    assign accept = alu_in_valid & ready_q;
    assign drain  = out_valid_q & ready_in;
    assign drop   = alu_in_valid & ~ready_q;

    // Per-container ALU; sub-action k+1 carries the opcode for container k.
    always_comb begin
        res_vec = '0;
        for (int k = 0; k < NUM_C; k++) begin
            logic [7:0]          op;
            logic [width_4B-1:0] a;
            logic [width_4B-1:0] b;
            logic [width_4B-1:0] o;
            op = action_in[(k+1)*ACT_LEN + ACT_LEN-1 -: 8];
            a  = alu_in_4B_1[k*width_4B +: width_4B];
            b  = alu_in_4B_2[k*width_4B +: width_4B];
            o  = alu_in_4B_3[k*width_4B +: width_4B];
            unique case (op)
                8'h01, 8'h09: res_vec[k*width_4B +: width_4B] = a + b;
                8'h02, 8'h0A: res_vec[k*width_4B +: width_4B] = a - b;
                8'h0E:        res_vec[k*width_4B +: width_4B] = b;
                8'h07:        res_vec[k*width_4B +: width_4B] = (a > b) ? a : b;
                8'h08:        res_vec[k*width_4B +: width_4B] = (a < b) ? a : b;
                8'h0B:        res_vec[k*width_4B +: width_4B] = (a == b) ? 32'd1 : 32'd0;
                default:      res_vec[k*width_4B +: width_4B] = o;
            endcase
        end
        phv_new = {res_vec, phv_remain_data};
    end

    // Output register / skid buffer steering and the saturating event counters.
    always_comb begin
        phv_d        = phv_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        drop_cnt_d   = drop_cnt_q;
        miss_cnt_d   = miss_cnt_q;

        if (drain) begin
            // The skid takes priority. An accept cannot happen while the skid
            // is full because ready_out is low then.
            if (skid_valid_q) begin
                phv_d        = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                phv_d = phv_new;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q) begin
                phv_d       = phv_new;
                out_valid_d = 1'b1;
            end else begin
                skid_d       = phv_new;
                skid_valid_d = 1'b1;
            end
        end

        ready_d = ~skid_valid_d;

        if (drop && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
        if (accept && !action_in_valid && miss_cnt_q != 16'hFFFF) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
        end
    end

    // State registers; reset discards any PHV held in the stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phv_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            drop_cnt_q   <= '0;
            miss_cnt_q   <= '0;
        end else begin
            phv_q        <= phv_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
            drop_cnt_q   <= drop_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign ready_out     = ready_q;
    assign phv_out       = phv_q;
    assign phv_out_valid = out_valid_q;
    assign drop_cnt      = drop_cnt_q;
    assign act_miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_alu_array_4b.sv
// tb_alu_array_4b: random and directed stimulus for alu_array_4b, checked
// against a reference model. The model treats the stage as a two-deep FIFO
// of expected PHVs.
module tb_alu_array_4b;

  localparam int W = 2304;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            in_valid;
  logic [2047:0]   a_v, b_v, o_v;
  logic [255:0]    rem_v;
  logic [4159:0]   act_v;
  logic            act_valid;
  logic            ready_out;
  logic [W-1:0]    phv_out;
  logic            phv_out_valid;
  logic            ready_in;
  logic [15:0]     drop_cnt;
  logic [15:0]     act_miss_cnt;

  alu_array_4b #(.STAGE_ID(0)) dut (
    .clk             (clk),
    .rst             (rst),
    .alu_in_valid    (in_valid),
    .alu_in_4B_1     (a_v),
    .alu_in_4B_2     (b_v),
    .alu_in_4B_3     (o_v),
    .phv_remain_data (rem_v),
    .action_in       (act_v),
    .action_in_valid (act_valid),
    .ready_out       (ready_out),
    .phv_out         (phv_out),
    .phv_out_valid   (phv_out_valid),
    .ready_in        (ready_in),
    .drop_cnt        (drop_cnt),
    .act_miss_cnt    (act_miss_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];
  logic [15:0]  drop_exp;
  logic [15:0]  miss_exp;
  logic         chk_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference ALU: the opcode rules written as plain arithmetic.
  function automatic logic [31:0] alu_ref(input logic [7:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] o);
    case (op)
      8'h01, 8'h09: return a + b;
      8'h02, 8'h0A: return a - b;
      8'h0E:        return b;
      8'h07:        return (a >= b) ? a : b;
      8'h08:        return (a <= b) ? a : b;
      8'h0B:        return (a == b) ? 32'd1 : 32'd0;
      default:      return o;
    endcase
  endfunction

  // Builds the PHV the model expects from the inputs currently applied.
  function automatic logic [W-1:0] ref_phv();
    logic [W-1:0] p;
    p[255:0] = rem_v;
    for (int k = 0; k < 64; k++) begin
      p[256 + 32*k +: 32] = alu_ref(act_v[(k+1)*64+63 -: 8], a_v[32*k +: 32],
                                    b_v[32*k +: 32], o_v[32*k +: 32]);
    end
    return p;
  endfunction

  function automatic logic [31:0] out_c(input int k);
    return phv_out[256 + 32*k +: 32];
  endfunction

  // Model: a two-entry queue. It pops on a downstream handshake, then pushes
  // on accept. ready is "fewer than two PHVs held".
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      drop_exp = '0;
      miss_exp = '0;
    end else begin
      bit acc;
      acc = in_valid && (exp_q.size() < 2);
      if (in_valid && !acc && drop_exp != 16'hFFFF) drop_exp = drop_exp + 16'd1;
      if (exp_q.size() > 0 && ready_in) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(ref_phv());
        if (!act_valid && miss_exp != 16'hFFFF) miss_exp = miss_exp + 16'd1;
      end
    end
  end

  task automatic check_outputs();
    check("valid", 32'(phv_out_valid), 32'(exp_q.size() > 0));
    check("ready", 32'(ready_out), 32'(exp_q.size() < 2));
    check("drop_cnt", 32'(drop_cnt), 32'(drop_exp));
    check("miss_cnt", 32'(act_miss_cnt), 32'(miss_exp));
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q[0];
      for (int k = 0; k < 64; k++)
        check($sformatf("c%0d", k), phv_out[256 + 32*k +: 32], e[256 + 32*k +: 32]);
      for (int j = 0; j < 8; j++)
        check($sformatf("rem%0d", j), phv_out[32*j +: 32], e[32*j +: 32]);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) check_outputs();
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [7:0] pick_op();
    case ($urandom_range(0, 11))
      0:  return 8'h01;
      1:  return 8'h09;
      2:  return 8'h02;
      3:  return 8'h0A;
      4:  return 8'h0E;
      5:  return 8'h07;
      6:  return 8'h08;
      7:  return 8'h0B;
      8:  return 8'h00;
      9:  return 8'h03;
      10: return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic rand_bundle();
    for (int k = 0; k < 64; k++) begin
      a_v[32*k +: 32] = $urandom;
      b_v[32*k +: 32] = ($urandom_range(0, 3) == 0) ? a_v[32*k +: 32] : $urandom;
      o_v[32*k +: 32] = $urandom;
    end
    for (int j = 0; j < 8; j++) rem_v[32*j +: 32] = $urandom;
    for (int s = 0; s < 65; s++) begin
      act_v[64*s +: 64] = {$urandom, $urandom};
      if (s > 0) act_v[64*s + 63 -: 8] = pick_op();
    end
  endtask

  task automatic set_c(input int k, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    act_v[(k+1)*64 + 63 -: 8] = op;
    a_v[32*k +: 32] = a;
    b_v[32*k +: 32] = b;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0]  orig1;
    logic [W-1:0] p1;

    rst = 1'b1; in_valid = 1'b0; act_valid = 1'b0; ready_in = 1'b0;
    a_v = '0; b_v = '0; o_v = '0; rem_v = '0; act_v = '0;
    repeat (3) next_cycle();

    // Reset state.
    check("rst_valid", 32'(phv_out_valid), 32'd0);
    check("rst_ready", 32'(ready_out), 32'd1);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_miss", 32'(act_miss_cnt), 32'd0);
    for (int j = 0; j < 72; j++) check($sformatf("rst_phv%0d", j), phv_out[32*j +: 32], 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    next_cycle();

    // Known-answer PHV: op 0x00 everywhere except a few containers.
    ready_in = 1'b1;
    rand_bundle();
    for (int s = 0; s < 65; s++) act_v[64*s + 63 -: 8] = 8'h00;
    set_c(0, 8'h01, 32'd5, 32'd7);
    set_c(3, 8'h02, 32'd1, 32'd2);
    set_c(4, 8'h0B, 32'h0000ABCD, 32'h0000ABCD);
    set_c(5, 8'h0E, 32'd0, 32'h0000DEAD);
    set_c(6, 8'h07, 32'd9, 32'd3);
    set_c(7, 8'h08, 32'd9, 32'd3);
    orig1 = o_v[63:32];
    in_valid = 1'b1; act_valid = 1'b1;
    @(negedge clk);
    check("kat_valid", 32'(phv_out_valid), 32'd1);
    check("kat_add", out_c(0), 32'd12);
    check("kat_pass1", out_c(1), orig1);
    check("kat_sub_wrap", out_c(3), 32'hFFFFFFFF);
    check("kat_eq", out_c(4), 32'd1);
    check("kat_set", out_c(5), 32'h0000DEAD);
    check("kat_max", out_c(6), 32'd9);
    check("kat_min", out_c(7), 32'd3);
    check("kat_rem0", phv_out[31:0], rem_v[31:0]);
    #1 in_valid = 1'b0;
    next_cycle();

    // Ten back-to-back PHVs with downstream always ready.
    for (int i = 0; i < 10; i++) begin
      rand_bundle(); in_valid = 1'b1;
      next_cycle();
      check("stream_ready", 32'(ready_out), 32'd1);
    end
    in_valid = 1'b0;
    next_cycle();
    check("stream_drop", 32'(drop_cnt), 32'd0);

    // Back-pressure: P1 held, P2 in the skid, then a dropped third PHV.
    ready_in = 1'b0;
    rand_bundle(); p1 = ref_phv(); in_valid = 1'b1;
    next_cycle();
    rand_bundle();
    next_cycle();
    in_valid = 1'b0;
    next_cycle();
    check("bp_ready_low", 32'(ready_out), 32'd0);
    check("bp_hold_p1", out_c(0), p1[256 +: 32]);
    rand_bundle(); in_valid = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    check("drop_one", 32'(drop_cnt), 32'd1);
    check("bp_still_p1", out_c(63), p1[W-1 -: 32]);
    ready_in = 1'b1;
    repeat (3) next_cycle();
    check("bp_ready_back", 32'(ready_out), 32'd1);

    // Accept without a valid action bundle.
    rand_bundle(); in_valid = 1'b1; act_valid = 1'b0;
    next_cycle();
    in_valid = 1'b0; act_valid = 1'b1;
    check("miss_one", 32'(act_miss_cnt), 32'd1);
    next_cycle();

    // Reset while the output register and the skid are both full.
    ready_in = 1'b0;
    rand_bundle(); in_valid = 1'b1;
    next_cycle();
    rand_bundle();
    next_cycle();
    in_valid = 1'b0;
    next_cycle();
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(phv_out_valid), 32'd0);
    check("arst_ready", 32'(ready_out), 32'd1);
    repeat (2) next_cycle();
    rst = 1'b0; ready_in = 1'b1;
    repeat (4) begin
      next_cycle();
      check("post_rst_empty", 32'(phv_out_valid), 32'd0);
    end

    // Random traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      rand_bundle();
      in_valid  = ($urandom_range(0, 3) != 0);
      ready_in  = ($urandom_range(0, 3) != 0);
      act_valid = ($urandom_range(0, 7) != 0);
      next_cycle();
    end
    in_valid = 1'b0; ready_in = 1'b1;
    repeat (4) next_cycle();
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_array_4b.md
Name: alu_array_4b

Overview:
- Per-stage action engine directly downstream of the stage crossbar.
- Receives 64 operand triples (operand A, operand B, original container) plus the one-cycle-delayed action bundle.
- Runs 64 parallel 32-bit ALUs and reassembles the PHV as {64 results, 256-bit remainder}.
- Hands the PHV to the next stage through a registered output with a one-entry skid buffer and valid/ready flow control.

Parameters:
STAGE_ID, 0, stage index; informational only, no effect on logic.
PHV_LEN, 4*8*64+256, output PHV width (2304).
ACT_LEN, 64, width of one sub-action.
C_NUM_PHVS, 65, number of sub-actions in the bundle; sub-action k+1 controls container k, sub-action 0 is unused.
width_4B, 32, container width.

Ports:
clk  in  1  single clock, all logic on rising edge.
rst  in  1  asynchronous, active-high reset.
alu_in_valid  in  1  operand bundle valid (single-cycle pulse per PHV).
alu_in_4B_1  in  width_4B*64  operand A; container k at [(k+1)*32-1 -: 32].
alu_in_4B_2  in  width_4B*64  operand B, same packing.
alu_in_4B_3  in  width_4B*64  original container values, same packing.
phv_remain_data  in  256  metadata/conditional tail, passed unmodified.
action_in  in  ACT_LEN*65  action bundle, aligned with alu_in_valid.
action_in_valid  in  1  action bundle valid.
ready_out  out  1  to crossbar ready_in; high when a new PHV can be accepted.
phv_out  out  PHV_LEN  {result[63],...,result[0], remain}; container k at [PHV_LEN-1-32*(63-k) -: 32].
phv_out_valid  out  1  output valid.
ready_in  in  1  downstream ready.
drop_cnt  out  16  saturating count of PHVs dropped (alu_in_valid while ready_out=0).
act_miss_cnt  out  16  saturating count of accepted PHVs with action_in_valid=0.

Behaviour:
- Reset (async, rst=1): phv_out=0, phv_out_valid=0, skid empty, skid data=0, ready_out=1, drop_cnt=0, act_miss_cnt=0.
- Opcode for container k: op = action_in[(k+1)*64+63 -: 8]. Operands a = A[k], b = B[k], o = 3rd[k]. All arithmetic is 32-bit unsigned, wrap-around, no saturation.
- Opcode results:
  - 0x01, 0x09: a+b.
  - 0x02, 0x0A: a-b.
  - 0x0E: b (set; crossbar supplies a=0).
  - 0x07: max(a,b).
  - 0x08: min(a,b).
  - 0x0B: (a==b) ? 1 : 0.
  - Any other opcode: o (pass-through).
- Accept condition: accept = alu_in_valid & ready_out. Results are computed combinationally and registered; there is no internal multi-cycle state.
- Latency: exactly 1 cycle from accept to phv_out_valid=1 when the output register is empty or drains that cycle.
- Output register update on accept:
  - If output empty, or (phv_out_valid & ready_in & skid empty): load the output register.
  - Otherwise: load the skid buffer.
- Drain: on phv_out_valid & ready_in, the output register loads from the skid if it is full (skid empties), else from a same-cycle accept, else phv_out_valid goes to 0.
- phv_out and phv_out_valid are held stable while phv_out_valid=1 & ready_in=0.
- ready_out is registered, = skid empty after the update. It drops the cycle after the skid fills and rises the cycle after the skid drains.
- Throughput: 1 PHV per cycle with ready_in held high. Capacity: 2 PHVs (output register plus skid).
- Simultaneous accept and drain with the skid full cannot occur, because ready_out=0 in that case.
- Drop: alu_in_valid & ~ready_out discards the data and increments drop_cnt. Output state is unaffected.
- act_miss_cnt increments on accept with action_in_valid=0. The PHV is still processed using action_in as presented.
- Both counters saturate at 16'hFFFF.
- Reset asserted mid-operation discards the output register and skid contents immediately; no partial PHV is emitted after rst deasserts.

Test Plan:
1. Reset, then ready_in=1; container 0: op 0x01, a=5, b=7 -> next cycle phv_out_valid=1 and container 0 = 12; remainder equals phv_remain_data; all other containers with op 0x00 equal their alu_in_4B_3 values.
2. Container 3: op 0x02, a=1, b=2 -> 0xFFFFFFFF (wrap). Container 4: op 0x0B, a=b=0xABCD -> 1. Container 5: op 0x0E, b=0xDEAD -> 0xDEAD. Container 6: op 0x07, a=9, b=3 -> 9.
3. ready_in=0, two back-to-back PHVs P1, P2 -> P1 held on phv_out; ready_out goes to 0 one cycle after P2 is accepted. Raise ready_in -> P1 then P2 emitted on consecutive cycles, then ready_out=1.
4. ready_in=1 with 10 consecutive alu_in_valid cycles -> 10 outputs on consecutive cycles, in order, ready_out stays 1, drop_cnt=0.
5. Fill the skid, then pulse alu_in_valid with ready_out=0 -> drop_cnt=1 and outputs remain P1, P2 only. A separate accept with action_in_valid=0 -> act_miss_cnt=1.
6. Assert rst while phv_out_valid=1 and the skid is full -> phv_out_valid=0 and ready_out=1 immediately; no stale PHV appears after release.
